// File: rtl/fio_pkg.sv
// -----------------------------------------------------------------------------
// fio_pkg
// Shared definitions for the FileIO read-back engine: FSM state encoding,
// default bus geometry and a helper that sizes the beat-index field.
// -----------------------------------------------------------------------------
package fio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int LINE_W_DEF = 256;
  localparam int BEAT_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int BEATS_DEF  = LINE_W_DEF / BEAT_W_DEF;

  // Width of a beat-index field; a one-beat line still gets a 1-bit field.
  function automatic int idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fio_mem_dump_if.sv
// -----------------------------------------------------------------------------
// fio_mem_dump_if
// Beat stream from the dump engine toward the host FileIO link.
//   valid/ready : handshake, a beat transfers on an edge with both high
//   data        : BEAT_W-bit beat
//   addr        : memory line the beat came from
//   beat        : beat index inside the line (0 = least significant word)
//   last        : final beat of the final line
// master = dump engine, slave = host link.
// -----------------------------------------------------------------------------
interface fio_mem_dump_if #(
  parameter int ADDR_W = fio_pkg::ADDR_W_DEF,
  parameter int BEAT_W = fio_pkg::BEAT_W_DEF,
  parameter int IDX_W  = fio_pkg::idx_w(fio_pkg::BEATS_DEF)
);
  logic              valid;
  logic              ready;
  logic [BEAT_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  beat;
  logic              last;

  modport master (output valid, data, addr, beat, last, input ready);
  modport slave  (input valid, data, addr, beat, last, output ready);
endinterface

// File: rtl/fio_line_serializer.sv
// -----------------------------------------------------------------------------
// fio_line_serializer
// Holds one captured memory line and presents it as a sequence of beats.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous abort, empties the buffer
//   load          : capture line, restart at beat 0 and raise valid
//   line          : line data to capture
//   ready         : downstream accepts the current beat
//   last_line     : the held line is the final one of the sweep
//   valid/data/beat/last : current beat
//   line_done     : handshake on the final beat of the line (this cycle)
// -----------------------------------------------------------------------------
module fio_line_serializer
  import fio_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int BEATS  = LINE_W / BEAT_W,
  parameter int IDX_W  = idx_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [LINE_W-1:0] line,
  input  logic              ready,
  input  logic              last_line,
  output logic              valid,
  output logic [BEAT_W-1:0] data,
  output logic [IDX_W-1:0]  beat,
  output logic              last,
  output logic              line_done
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  logic [LINE_W-1:0] line_reg;
  logic [IDX_W-1:0]  beat_reg;
  logic              valid_reg;
  logic [BEAT_W-1:0] beat_words [BEATS];
  logic              final_beat;

  // Slice the buffer into beat-sized words; beat 0 is the low word.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign beat_words[gi] = line_reg[gi*BEAT_W +: BEAT_W];
  end

  assign final_beat = (beat_reg == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_reg  <= '0;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      line_reg  <= '0;
      beat_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      line_reg  <= line;
      beat_reg  <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      // Fields only move on a handshake, so a stalled beat stays put.
      if (final_beat) begin
        beat_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign valid     = valid_reg;
  assign data      = valid_reg ? beat_words[beat_reg] : '0;
  assign beat      = beat_reg;
  assign last      = valid_reg && last_line && final_beat;
  assign line_done = valid_reg && ready && final_beat;

endmodule

// File: rtl/fio_mem_dump.sv
// -----------------------------------------------------------------------------
// fio_mem_dump
// FileIO read-back engine. Once start is seen it walks memory lines
// 0..DEPTH-1 through the FIO read port, waits RD_LAT cycles per line for the
// read data, captures it and streams it out as LINE_W/BEAT_W beats.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start          : level request; a new dump needs start to fall and rise
//   clear          : synchronous abort back to IDLE
//   fio_memwrite   : write enable to the FIO port, tied low (read-only block)
//   fio_addr       : line address being read
//   fio_read_data  : memory read data, valid RD_LAT cycles after fio_addr
//   busy           : engine owns the FIO port (READ/SEND)
//   done           : sweep complete
//   stream         : beat stream toward the host (master side)
// -----------------------------------------------------------------------------
module fio_mem_dump
  import fio_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  output logic              fio_memwrite,
  output logic [ADDR_W-1:0] fio_addr,
  input  logic [LINE_W-1:0] fio_read_data,
  output logic              busy,
  output logic              done,
  fio_mem_dump_if.master    stream
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int IDX_W  = idx_w(BEATS);
  localparam int WAIT_W = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              load;
  logic              line_done;
  logic              last_line;

  // The RD_LAT-th edge spent in READ is the capture edge.
  assign load      = (state_reg == ST_READ) && (wait_reg == WAIT_LAST);
  assign last_line = (addr_reg == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      wait_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (clear) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      wait_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_READ;
            addr_reg  <= '0;
            wait_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_READ: begin
          if (load) begin
            state_reg <= ST_SEND;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        ST_SEND: begin
          if (line_done) begin
            if (last_line) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              // Address only moves on READ entry; it never wraps past DEPTH-1.
              state_reg <= ST_READ;
              addr_reg  <= addr_reg + 1'b1;
              wait_reg  <= '0;
            end
          end
        end
        ST_DONE: begin
          // Stay parked until start drops so one request yields one dump.
          if (!start) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  fio_line_serializer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .IDX_W  (IDX_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .line      (fio_read_data),
    .ready     (stream.ready),
    .last_line (last_line),
    .valid     (stream.valid),
    .data      (stream.data),
    .beat      (stream.beat),
    .last      (stream.last),
    .line_done (line_done)
  );

  assign stream.addr  = addr_reg;
  assign fio_addr     = addr_reg;
  assign fio_memwrite = 1'b0;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_fio_mem_dump.sv
// -----------------------------------------------------------------------------
// tb_fio_mem_dump
// Directed bench for fio_mem_dump. Two instances: dut (RD_LAT=2) and
// dut3 (RD_LAT=3). Each has a memory model that drives valid line data only
// in the single cycle RD_LAT cycles after a new read request and X otherwise.
// Pattern 0: every beat of line L is {L,24'hA5A5A5}.
// Pattern 1: same, with the beat index XORed into the low bits.
// -----------------------------------------------------------------------------
module tb_fio_mem_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start3 = 1'b0;
  logic clear = 1'b0;
  logic rdy = 1'b1;
  logic sel3 = 1'b0;
  int   pat_sel = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wire         fio_memwrite, fio_memwrite3;
  wire [7:0]   fio_addr, fio_addr3;
  wire         busy, busy3, done, done3;
  logic [255:0] rd_data, rd_data3;

  fio_mem_dump_if #(.ADDR_W(8), .BEAT_W(32), .IDX_W(3)) s_if ();
  fio_mem_dump_if #(.ADDR_W(8), .BEAT_W(32), .IDX_W(3)) s3_if ();

  assign s_if.ready  = rdy;
  assign s3_if.ready = rdy;

  fio_mem_dump #(.DEPTH(256), .ADDR_W(8), .LINE_W(256), .BEAT_W(32), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .fio_memwrite(fio_memwrite), .fio_addr(fio_addr), .fio_read_data(rd_data),
    .busy(busy), .done(done), .stream(s_if)
  );

  fio_mem_dump #(.DEPTH(256), .ADDR_W(8), .LINE_W(256), .BEAT_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .clear(clear),
    .fio_memwrite(fio_memwrite3), .fio_addr(fio_addr3), .fio_read_data(rd_data3),
    .busy(busy3), .done(done3), .stream(s3_if)
  );

  // Observation mux: which instance the current step is looking at.
  wire        o_valid = sel3 ? s3_if.valid : s_if.valid;
  wire [31:0] o_data  = sel3 ? s3_if.data  : s_if.data;
  wire [7:0]  o_addr  = sel3 ? s3_if.addr  : s_if.addr;
  wire [2:0]  o_beat  = sel3 ? s3_if.beat  : s_if.beat;
  wire        o_last  = sel3 ? s3_if.last  : s_if.last;
  wire        o_busy  = sel3 ? busy3 : busy;
  wire        o_done  = sel3 ? done3 : done;
  wire        o_wr    = sel3 ? fio_memwrite3 : fio_memwrite;
  wire [7:0]  o_faddr = sel3 ? fio_addr3 : fio_addr;

  function automatic logic [31:0] exp_beat(input int l, input int b, input int pat);
    logic [31:0] w;
    logic [7:0]  lb;
    lb = l[7:0];
    w = {lb, 24'hA5A5A5};
    if (pat != 0) w = w ^ 32'(b);
    return w;
  endfunction

  function automatic logic [255:0] mem_line(input logic [7:0] a, input int pat);
    logic [255:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[b*32 +: 32] = exp_beat(int'(a), b, pat);
    return r;
  endfunction

  // Memory models: age counts cycles since the last read request
  // (address change or busy rising); data is valid only at age == RD_LAT.
  int         age2 = 15, age3 = 15;
  logic [7:0] pa2 = 8'd0, pa3 = 8'd0;
  logic       pb2 = 1'b0, pb3 = 1'b0;

  always @(negedge clk) begin
    if ((fio_addr !== pa2) || (busy && !pb2)) age2 = 1;
    else if (age2 < 15) age2 = age2 + 1;
    pa2 = fio_addr;
    pb2 = busy;
    rd_data = (age2 == 2) ? mem_line(fio_addr, pat_sel) : {256{1'bx}};
  end

  always @(negedge clk) begin
    if ((fio_addr3 !== pa3) || (busy3 && !pb3)) age3 = 1;
    else if (age3 < 15) age3 = age3 + 1;
    pa3 = fio_addr3;
    pb3 = busy3;
    rd_data3 = (age3 == 3) ? mem_line(fio_addr3, pat_sel) : {256{1'bx}};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drop start for one edge (DONE -> IDLE), then raise it; next edge is E0.
  task automatic arm();
    if (sel3) start3 = 1'b0; else start = 1'b0;
    @(negedge clk);
    chk("rearm_idle", {o_done, o_busy, o_valid}, 3'b000);
    if (sel3) start3 = 1'b1; else start = 1'b1;
  endtask

  // Full sweep; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1.
  // lat > 0 also checks first-valid and done timing for that read latency.
  task automatic run_sweep(input string tag, input int mode, input int lat);
    int cyc, el, eb, nb, fv, dc, ph, nlast;
    logic held, wr_seen;
    logic [31:0] hd, first_data, last_data;
    logic [7:0] ha;
    logic [2:0] hb;
    logic hl;
    el = 0; eb = 0; nb = 0; fv = -1; dc = -1; ph = 0; nlast = 0;
    held = 1'b0; wr_seen = 1'b0; hd = '0; ha = '0; hb = '0; hl = 1'b0;
    first_data = '0; last_data = '0;
    arm();
    cyc = 0;
    while (dc < 0 && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      rdy = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
      ph++;
      if (o_wr !== 1'b0) wr_seen = 1'b1;
      if (o_valid === 1'b1 && fv < 0) fv = cyc;
      if (held)
        chk("stall_hold", {o_valid, o_data, o_addr, o_beat, o_last}, {1'b1, hd, ha, hb, hl});
      if (o_valid === 1'b1 && rdy) begin
        chk("beat", {o_data, o_addr, o_beat, o_last},
            {exp_beat(el, eb, pat_sel), 8'(el), 3'(eb), (el == 255 && eb == 7)});
        if (nb == 0) first_data = o_data;
        last_data = o_data;
        if (o_last === 1'b1) nlast++;
        nb++;
        if (eb == 7) begin eb = 0; el++; end else eb++;
      end
      held = (o_valid === 1'b1) && !rdy;
      hd = o_data; ha = o_addr; hb = o_beat; hl = o_last;
      if (o_done === 1'b1) dc = cyc;
    end
    rdy = 1'b1;
    chk("done_seen", 64'(dc > 0), 64'd1);
    chk("beat_count", 64'(nb), 64'd2048);
    chk("last_count", 64'(nlast), 64'd1);
    chk("memwrite_low", 64'(wr_seen), 64'd0);
    chk("line0_beat0", 64'(first_data), 64'h00A5A5A5);
    chk("busy_at_done", 64'(o_busy), 64'd0);
    if (pat_sel == 0) chk("line255_beat7", 64'(last_data), 64'hFFA5A5A5);
    if (lat > 0) begin
      // First valid follows edge E0+RD_LAT; done rises at E0 + 256*(RD_LAT+8).
      chk("first_valid_cyc", 64'(fv), 64'(lat + 1));
      chk("done_cycle", 64'(dc - 1), 64'(256 * (lat + 8)));
    end
    $display("step %s: beats=%0d done_after=%0d cycles first_valid=%0d", tag, nb, dc - 1, fv);
  endtask

  // Start a dump and stop at the negedge where the given beat is presented.
  task automatic run_until(input int line, input int beat);
    int cyc;
    logic found;
    found = 1'b0;
    arm();
    cyc = 0;
    while (!found && cyc < 600) begin
      @(negedge clk);
      cyc++;
      rdy = 1'b1;
      if (o_valid === 1'b1 && o_addr == 8'(line) && o_beat == 3'(beat)) found = 1'b1;
    end
    chk("reach_point", 64'(found), 64'd1);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {o_valid, o_data, o_addr, o_beat, o_last, o_busy, o_done, o_faddr, o_wr}, 64'd0);
    $display("step reset: valid=%0b busy=%0b done=%0b", o_valid, o_busy, o_done);
    @(negedge clk);
    rst = 1'b1;

    // Full sweep, always ready, pattern 0.
    pat_sel = 0;
    run_sweep("full", 0, 2);

    // Hold start through DONE: no second dump.
    begin
      logic busy_seen;
      busy_seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (o_busy !== 1'b0 || o_valid !== 1'b0) busy_seen = 1'b1;
      end
      chk("hold_no_redump", 64'(busy_seen), 64'd0);
      chk("hold_done", {o_done, o_busy}, 2'b10);
      $display("step hold: done=%0b busy=%0b", o_done, o_busy);
    end

    // Re-arm: one cycle low then high gives a second identical dump.
    run_sweep("rearm", 0, 2);

    // Backpressure with ready 1,0,0,1 and a beat-distinct pattern.
    pat_sel = 1;
    run_sweep("backpressure", 1, 0);

    // Clear at line 17 beat 4, together with a handshake.
    run_until(17, 4);
    clear = 1'b1;
    start = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_state", {o_valid, o_data, o_addr, o_beat, o_last, o_busy, o_done, o_faddr}, 64'd0);
    $display("step clear: valid=%0b fio_addr=%0d busy=%0b", o_valid, o_faddr, o_busy);
    run_sweep("after_clear", 0, 2);

    // Asynchronous reset while line 5 beat 3 is on the stream.
    run_until(5, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_reset", {o_valid, o_data, o_addr, o_beat, o_last, o_busy, o_done, o_faddr}, 64'd0);
    $display("step async_reset: valid=%0b beat=%0d addr=%0d", o_valid, o_beat, o_addr);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {o_done, o_busy, o_valid}, 3'b000);

    // Read latency 3 instance.
    sel3 = 1'b1;
    pat_sel = 1;
    run_sweep("rd_lat3", 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fio_mem_dump.md
Name: fio_mem_dump

Overview:
- Synthesizable FileIO read-back engine: the reader counterpart of the FileIO memory loader.
- After the task manager reports completion, it sweeps data memory through the FIO read port and captures each 256-bit line.
- It serializes every line into 32-bit beats on a valid/ready stream toward the host FileIO link.
- It sits beside gpu_top_checking and owns FIO_ADDR/FIO_MEMWRITE while busy.

Parameters:
- DEPTH, 256, number of memory lines swept (addresses 0..DEPTH-1)
- ADDR_W, 8, width of FIO address; must satisfy 2^ADDR_W >= DEPTH
- LINE_W, 256, memory line width
- BEAT_W, 32, output beat width; LINE_W must be a multiple of BEAT_W
- RD_LAT, 2, cycles from FIO_ADDR change to valid FIO_READ_DATA; must be >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; begin dump when high in IDLE (tie to finished_TM_FIO)
- clear  in  1  synchronous abort; returns to IDLE next edge, highest priority after rst
- fio_memwrite  out  1  memory write enable to FIO port; always 0 from this block
- fio_addr  out  ADDR_W  memory line address being read
- fio_read_data  in  LINE_W  memory read data, valid RD_LAT cycles after fio_addr
- busy  out  1  high in READ/SEND; top uses it to mux FIO port ownership
- done  out  1  high in DONE
- out_valid  out  1  beat valid
- out_ready  in  1  host accepts beat
- out_data  out  BEAT_W  current beat
- out_addr  out  ADDR_W  line address of current beat
- out_beat  out  log2(LINE_W/BEAT_W)  beat index within line, 0 = bits [BEAT_W-1:0]
- out_last  out  1  final beat of final line

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; fio_addr=0, fio_memwrite=0, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, out_beat=0, out_last=0, wait counter=0, line buffer=0.
- States: IDLE, READ, SEND, DONE.
- IDLE: start=1 at an edge -> READ. fio_addr=0 and the wait counter clears.
- READ: fio_addr holds the current line address L. The wait counter increments each cycle. On the RD_LAT-th edge in READ, fio_read_data is captured into the line buffer, beat=0 is set, and the state moves to SEND. READ therefore lasts exactly RD_LAT cycles.
- SEND: out_valid=1, out_data=buffer[beat*BEAT_W +: BEAT_W], out_addr=L.
  - An edge with out_valid&out_ready advances beat.
  - Handshake on beat LINE_W/BEAT_W-1 (7 by default):
    - L<DEPTH-1: fio_addr=L+1, state READ.
    - L=DEPTH-1: state DONE.
- Backpressure: while out_valid & !out_ready, out_data, out_addr, out_beat and out_last must hold stable. out_valid never drops without a handshake except on clear or rst.
- out_last=1 only during SEND with L=DEPTH-1 and beat=LINE_W/BEAT_W-1.
- DONE: done=1, busy=0, out_valid=0. Stays in DONE while start=1; start=0 -> IDLE (re-arm). A new dump requires start to fall and rise again.
- Timing with out_ready=1 and defaults: start sampled at edge E0; READ occupies cycles E0..E0+1; first out_valid is after edge E0+2. Each line costs RD_LAT+8 = 10 cycles; the full sweep takes 2560 cycles. done rises at edge E0+2560.
- fio_addr changes only on READ entry. No wrap-around beyond DEPTH-1. Address arithmetic is ADDR_W-bit unsigned.
- clear=1: next edge -> IDLE with all outputs at reset values. clear has priority over start and over a simultaneous handshake.
- fio_memwrite is never asserted; the block is read-only.

Decomposition:
- Shared package fio_pkg: state encoding (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3), default LINE_W/BEAT_W/ADDR_W constants, BEATS=LINE_W/BEAT_W.
- One natural sub-module, fio_line_serializer: line buffer plus beat counter with valid/ready hold. The top FSM handles address sequencing and read-latency wait.

Test Plan:
- Reset mid-SEND: dump running with out_beat=3 on line 5, rst=0 -> all outputs 0 immediately (asynchronous). After release, IDLE with done=0.
- Full sweep, out_ready=1: memory line L = {8{L,24'hA5A5A5}} (L zero-extended to 8 bits), start=1 -> 2048 beats in address order.
  - Beat b of line L equals {L[7:0],24'hA5A5A5}.
  - out_last only on beat 2047.
  - done at cycle 2560 after start.
  - fio_memwrite=0 throughout.
- Backpressure: out_ready toggles 1,0,0,1 pattern -> no beat lost or duplicated; fields stable during stalls; line 0 beat 0 = memory[0][31:0]=32'h00A5A5A5.
- Read latency check: RD_LAT=3 and a memory model returning X except exactly 3 cycles after the address -> captured data correct for lines 0, 1, 255; 11 cycles per line.
- clear abort: clear=1 at line 17 beat 4 -> next cycle IDLE, out_valid=0, fio_addr=0. Restart with start -> sweep begins again at line 0.
- Re-arm: hold start=1 through DONE -> no second dump. Drop start 1 cycle then raise it -> second identical 2048-beat dump.
